rice_cost_accumulator: RTL and testbench
========================================

# rice_cost_accumulator

Streaming producer for the 12-way minimum comparator in the FLAC hardware encoder. The block accepts one signed residual per cycle, zig-zag folds it, and accumulates the exact Rice-coded bit cost of the partition for every parameter k = 0..11. At each partition boundary it presents the 12 totals on registered outputs with a one-cycle done strobe, ready to drive the comparator inputs 0..11. Partitions run back-to-back with no bubble.

## Interface
- RES_W, 16, residual width (signed two's complement)
- PARTITION_LEN, 16, residuals per partition (2..65536)
- SUM_W, 32, width of each accumulated cost

- iClock  in  1  rising-edge clock
- iReset  in  1  asynchronous, active-low reset
- iEnable  in  1  high = run; low = synchronous flush of pipeline, counter and accumulators
- iValid  in  1  iResidual valid this cycle
- iResidual  in  RES_W  signed residual
- oSum0..oSum11  out  SUM_W  partition cost for k = 0..11
- oDone  out  1  one-cycle strobe: oSum0..oSum11 updated this cycle
- oCount  out  16  residuals accepted in the current partition

## Operation
- Fold: u = (r >= 0) ? 2r : -2r-1, unsigned RES_W+1 bits.
- Cost per sample for k: c_k = (u >> k) + 1 + k, computed in RES_W+2 bits, zero-extended to SUM_W.
- 3-stage pipeline, each stage carries valid and a last flag:
  - S1: register fold u; last = (oCount == PARTITION_LEN-1); update counter.
  - S2: register c_0..c_11.
  - S3: acc_k <= acc_k + c_k. If last: oSum_k <= acc_k + c_k, acc_k <= 0, oDone <= 1.
- Counter: increments on each accepted iValid; wraps to 0 after PARTITION_LEN-1. oCount reflects S1 counter.
- iValid gaps: bubbles travel down the pipeline; accumulators hold.
- iEnable low: all pipeline valids, counter and acc_k cleared at next edge; oSum_k hold last published values; oDone forced 0. iValid ignored while iEnable low.
- oSum_k change only on a last-sample S3 cycle; otherwise hold.

## Timing
- Reset (iReset low, async): oSum0..oSum11 = 0, oDone = 0, oCount = 0, acc and pipeline valids = 0. Release synchronised externally.
- Latency: last residual captured on edge E0 -> oSum/oDone valid after edge E2 (3 edges including capture). oDone high exactly one cycle.
- Back-to-back: first residual of partition n+1 may arrive on the cycle after the last of partition n; its S3 add lands on a zeroed accumulator (same-cycle clear-and-load, not add to old).
- Reset mid-partition: partial partition discarded, no oDone.
- iEnable falling with last sample in S2/S3: in-flight samples discarded, no oDone.
- PARTITION_LEN = 65536: counter wraps naturally at 16 bits.

## Configuration
- ACC_SATURATE_EN defined: every acc_k and published oSum_k add saturates at 2^SUM_W-1; once saturated stays saturated until partition clear.
- Undefined: plain modulo-2^SUM_W addition (wrap), smaller adder.

## Test plan
- PARTITION_LEN=4, residuals 0,-1,1,2 contiguous -> one oDone; oSum0=11, oSum1=11, oSum2=13, oSum11=48; oDone 3 edges after last capture.
- Same stimulus twice back-to-back, no gap -> two oDone 4 cycles apart, identical sums (accumulator clear verified).
- Same 4 residuals with iValid low for 3 cycles between each -> identical sums, oDone once, oCount steps 1,2,3,0.
- Assert iReset low after 2 of 4 residuals, then send 0,-1,1,2 -> outputs 0 during reset, single oDone with sums from first test.
- iEnable low for one cycle mid-partition -> no oDone for that partition; next full partition gives correct sums.
- PARTITION_LEN=65536, all residuals -32768 (u=65535, c_0=65536) -> oSum0 = 0xFFFFFFFF with ACC_SATURATE_EN, 0x00000000 without; oSum11 = 65536*(31+12)=2818048 both.

Source files
------------

// File: rtl/rice_cost_accumulator_if.sv
// Residual stream in, twelve Rice partition costs out.
// Clock and reset travel as plain ports beside this bundle.
interface rice_cost_accumulator_if #(
  parameter int unsigned RES_W = 16,
  parameter int unsigned SUM_W = 32
);
  logic             iEnable;
  logic             iValid;
  logic [RES_W-1:0] iResidual;
  logic [SUM_W-1:0] oSum0, oSum1, oSum2, oSum3, oSum4, oSum5;
  logic [SUM_W-1:0] oSum6, oSum7, oSum8, oSum9, oSum10, oSum11;
  logic             oDone;
  logic [15:0]      oCount;

  modport master (
    output iEnable, iValid, iResidual,
    input  oSum0, oSum1, oSum2, oSum3, oSum4, oSum5,
    input  oSum6, oSum7, oSum8, oSum9, oSum10, oSum11,
    input  oDone, oCount
  );

  modport slave (
    input  iEnable, iValid, iResidual,
    output oSum0, oSum1, oSum2, oSum3, oSum4, oSum5,
    output oSum6, oSum7, oSum8, oSum9, oSum10, oSum11,
    output oDone, oCount
  );
endinterface

// File: rtl/rice_cost_accumulator.sv
// Rice cost accumulator: zig-zag folds each residual and accumulates the exact
// Rice-coded bit cost of the partition for k = 0..11 through a 3-stage pipeline.
// Optional macro ACC_SATURATE_EN: accumulators saturate instead of wrapping.
module rice_cost_accumulator #(
  parameter int unsigned RES_W         = 16,
  parameter int unsigned PARTITION_LEN = 16,
  parameter int unsigned SUM_W         = 32
) (
  input logic                    iClock,
  input logic                    iReset,
  rice_cost_accumulator_if.slave bus
);
  localparam int unsigned NumK = 12;
  localparam int unsigned UW   = RES_W + 1;
  localparam int unsigned CW   = RES_W + 2;
  // Index of the last residual; 65536 becomes 16'hFFFF, so the counter wraps naturally.
  localparam logic [15:0] LastIdx = 16'(PARTITION_LEN - 1);

  function automatic logic [SUM_W-1:0] acc_add(input logic [SUM_W-1:0] a,
                                               input logic [CW-1:0] c);
`ifdef ACC_SATURATE_EN
    logic [SUM_W:0] s;
    s = {1'b0, a} + (SUM_W + 1)'(c);
    // Every cost is at least 1, so a saturated total stays saturated.
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
`else
    return a + SUM_W'(c);
`endif
  endfunction

  logic [15:0]      count_q, count_d;
  logic             v1_q, v1_d, last1_q, last1_d;
  logic [UW-1:0]    u_q, u_d;
  logic             v2_q, v2_d, last2_q, last2_d;
  logic [CW-1:0]    c_q [NumK];
  logic [CW-1:0]    c_d [NumK];
  logic [SUM_W-1:0] acc_q [NumK];
  logic [SUM_W-1:0] acc_d [NumK];
  logic [SUM_W-1:0] sum_q [NumK];
  logic [SUM_W-1:0] sum_d [NumK];
  logic             done_q, done_d;
  logic             accept, is_last;

  assign accept  = bus.iEnable & bus.iValid;
  assign is_last = (count_q == LastIdx);

  // S1: fold, partition position counter and last-sample tag.
  always_comb begin
    // Zig-zag: 2r for r >= 0, -2r-1 otherwise, done as shift-and-xor with the sign.
    u_d     = {bus.iResidual, 1'b0} ^ {UW{bus.iResidual[RES_W-1]}};
    v1_d    = accept;
    last1_d = accept & is_last;
    count_d = count_q;
    if (!bus.iEnable) begin
      count_d = '0;
    end else if (bus.iValid) begin
      count_d = is_last ? 16'd0 : count_q + 16'd1;
    end
  end

  // S2: per-k sample cost (u >> k) + 1 + k.
  always_comb begin
    v2_d    = bus.iEnable & v1_q;
    last2_d = last1_q;
    for (int k = 0; k < NumK; k++) begin
      c_d[k] = CW'(u_q >> k) + CW'(k + 1);
    end
  end

  // S3: accumulate; on the last sample publish the total and restart from zero.
  always_comb begin
    done_d = 1'b0;
    for (int k = 0; k < NumK; k++) begin
      acc_d[k] = acc_q[k];
      sum_d[k] = sum_q[k];
    end
    if (!bus.iEnable) begin
      for (int k = 0; k < NumK; k++) begin
        acc_d[k] = '0;
      end
    end else if (v2_q) begin
      done_d = last2_q;
      for (int k = 0; k < NumK; k++) begin
        if (last2_q) begin
          sum_d[k] = acc_add(acc_q[k], c_q[k]);
          acc_d[k] = '0;
        end else begin
          acc_d[k] = acc_add(acc_q[k], c_q[k]);
        end
      end
    end
  end

  // Pipeline, counter, accumulator and published-sum registers.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      count_q <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      u_q     <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < NumK; k++) begin
        c_q[k]   <= '0;
        acc_q[k] <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      count_q <= count_d;
      v1_q    <= v1_d;
      last1_q <= last1_d;
      if (accept) u_q <= u_d;
      v2_q    <= v2_d;
      last2_q <= last2_d;
      done_q  <= done_d;
      for (int k = 0; k < NumK; k++) begin
        if (v1_q) c_q[k] <= c_d[k];
        acc_q[k] <= acc_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign bus.oSum0  = sum_q[0];
  assign bus.oSum1  = sum_q[1];
  assign bus.oSum2  = sum_q[2];
  assign bus.oSum3  = sum_q[3];
  assign bus.oSum4  = sum_q[4];
  assign bus.oSum5  = sum_q[5];
  assign bus.oSum6  = sum_q[6];
  assign bus.oSum7  = sum_q[7];
  assign bus.oSum8  = sum_q[8];
  assign bus.oSum9  = sum_q[9];
  assign bus.oSum10 = sum_q[10];
  assign bus.oSum11 = sum_q[11];
  assign bus.oDone  = done_q;
  assign bus.oCount = count_q;
endmodule

// File: tb/tb_rice_cost_accumulator.sv
// Bench for rice_cost_accumulator: a 4-residual instance for the functional cases
// and a 65536-residual instance for the overflow case, checked by queue scoreboards.
module tb_rice_cost_accumulator;
  typedef struct packed {
    logic [11:0][31:0] sums;
    logic [31:0]       cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cyc = '0;
  int          total = 0;
  int          bad = 0;
  exp_t        q_s[$];
  exp_t        q_b[$];

  // Hand-computed costs for residuals 0,-1,1,2 (u = 0,1,2,4) for k = 0..11.
  int unsigned       small_tab[12] = '{11, 11, 13, 16, 20, 24, 28, 32, 36, 40, 44, 48};
  logic [11:0][31:0] small_sums;
  logic signed [15:0] rt[4] = '{16'sd0, -16'sd1, 16'sd1, 16'sd2};
`ifdef ACC_SATURATE_EN
  logic [31:0] big_k0 = 32'hFFFF_FFFF;
`else
  logic [31:0] big_k0 = 32'h0000_0000;
`endif
  logic [31:0] big_k1  = 32'h8001_0000;  // 65536 * 32769
  logic [31:0] big_k11 = 32'd2818048;    // 65536 * 43

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  rice_cost_accumulator_if #(.RES_W(16), .SUM_W(32)) bs ();
  rice_cost_accumulator_if #(.RES_W(16), .SUM_W(32)) bb ();

  rice_cost_accumulator #(.RES_W(16), .PARTITION_LEN(4), .SUM_W(32)) dut_s (
    .iClock (clk),
    .iReset (rst_n),
    .bus    (bs)
  );

  rice_cost_accumulator #(.RES_W(16), .PARTITION_LEN(65536), .SUM_W(32)) dut_b (
    .iClock (clk),
    .iReset (rst_n),
    .bus    (bb)
  );

  logic [11:0][31:0] ss, sb;
  assign ss = {bs.oSum11, bs.oSum10, bs.oSum9, bs.oSum8, bs.oSum7, bs.oSum6,
               bs.oSum5, bs.oSum4, bs.oSum3, bs.oSum2, bs.oSum1, bs.oSum0};
  assign sb = {bb.oSum11, bb.oSum10, bb.oSum9, bb.oSum8, bb.oSum7, bb.oSum6,
               bb.oSum5, bb.oSum4, bb.oSum3, bb.oSum2, bb.oSum1, bb.oSum0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  // Small-DUT monitor: every oDone must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bs.oDone) begin
      if (q_s.size() == 0) begin
        check("small unexpected oDone", 32'(bs.oDone), 32'd0);
      end else begin
        exp_t e;
        e = q_s.pop_front();
        check("small oDone cycle", cyc, e.cyc);
        for (int k = 0; k < 12; k++) check($sformatf("small oSum%0d", k), ss[k], e.sums[k]);
      end
    end
  end

  // Large-DUT monitor.
  always @(negedge clk) begin
    if (rst_n && bb.oDone) begin
      if (q_b.size() == 0) begin
        check("big unexpected oDone", 32'(bb.oDone), 32'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("big oDone cycle", cyc, e.cyc);
        check("big oSum0", sb[0], e.sums[0]);
        check("big oSum1", sb[1], e.sums[1]);
        check("big oSum11", sb[11], e.sums[11]);
      end
    end
  end

  task automatic drive(input logic en, input logic v, input logic signed [15:0] r);
    @(negedge clk);
    bs.iEnable   = en;
    bs.iValid    = v;
    bs.iResidual = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 16'sd0);
  endtask

  // One partition 0,-1,1,2 with `gap` idle cycles after each sample; optional oCount checks.
  task automatic send_part(input int gap, input bit chk_cnt);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, rt[i]);
      if (i == 3) begin
        e.sums = small_sums;
        e.cyc  = cyc + 32'd3;
        q_s.push_back(e);
      end
      for (int g = 0; g < gap; g++) begin
        drive(1'b1, 1'b0, 16'sd0);
        if (g == 0 && chk_cnt) check($sformatf("oCount after sample %0d", i),
                                     32'(bs.oCount), 32'((i + 1) % 4));
      end
    end
  endtask

  initial begin
    exp_t e;
    for (int k = 0; k < 12; k++) small_sums[k] = small_tab[k];
    bs.iEnable = 1'b0; bs.iValid = 1'b0; bs.iResidual = '0;
    bb.iEnable = 1'b1; bb.iValid = 1'b0; bb.iResidual = '0;
    repeat (3) @(negedge clk);
    check("reset oSum0", bs.oSum0, 32'd0);
    check("reset oSum11", bs.oSum11, 32'd0);
    check("reset oDone", 32'(bs.oDone), 32'd0);
    check("reset oCount", 32'(bs.oCount), 32'd0);
    check("reset big oSum0", bb.oSum0, 32'd0);
    rst_n = 1'b1;

    // Single contiguous partition.
    send_part(0, 1'b0);
    idle(6);
    // Two partitions back-to-back.
    send_part(0, 1'b0);
    send_part(0, 1'b0);
    idle(6);
    // Three-cycle bubbles between samples, with counter steps.
    send_part(3, 1'b1);
    idle(6);

    // Reset after two samples: partial partition discarded.
    drive(1'b1, 1'b1, rt[0]);
    drive(1'b1, 1'b1, rt[1]);
    @(negedge clk);
    bs.iValid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid-reset oSum0", bs.oSum0, 32'd0);
    check("mid-reset oSum2", bs.oSum2, 32'd0);
    check("mid-reset oCount", 32'(bs.oCount), 32'd0);
    check("mid-reset oDone", 32'(bs.oDone), 32'd0);
    rst_n = 1'b1;
    send_part(0, 1'b0);
    idle(6);

    // Enable low one cycle mid-partition: that partition never completes.
    drive(1'b1, 1'b1, rt[0]);
    drive(1'b1, 1'b1, rt[1]);
    drive(1'b0, 1'b1, rt[2]);
    check("flush oCount", 32'(bs.oCount), 32'd2);
    drive(1'b1, 1'b0, 16'sd0);
    check("post-flush oCount", 32'(bs.oCount), 32'd0);
    send_part(0, 1'b0);
    idle(6);

    // Enable falls while the last sample sits in S2: no oDone.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, rt[i]);
    drive(1'b1, 1'b0, 16'sd0);
    drive(1'b0, 1'b0, 16'sd0);
    idle(6);
    send_part(0, 1'b0);
    idle(8);

    // Full 65536-residual partition of -32768 on the large instance.
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      bb.iValid    = 1'b1;
      bb.iResidual = 16'h8000;
      if (i == 65535) begin
        e.sums     = '0;
        e.sums[0]  = big_k0;
        e.sums[1]  = big_k1;
        e.sums[11] = big_k11;
        e.cyc      = cyc + 32'd3;
        q_b.push_back(e);
      end
    end
    @(negedge clk);
    bb.iValid = 1'b0;
    repeat (10) @(negedge clk);

    check("small queue drained", 32'(q_s.size()), 32'd0);
    check("big queue drained", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
